// File: rtl/merge4_1_if.sv
// Lane-to-output handshake bundle for the four-lane round-robin merger.
// Upstream lanes and the downstream sink sit on the master side; the merger is the slave.
interface merge4_1_if #(
    parameter int number_bits = 16
);
    logic [number_bits-1:0] in1;
    logic [number_bits-1:0] in2;
    logic [number_bits-1:0] in3;
    logic [number_bits-1:0] in4;
    logic                   valid1;
    logic                   valid2;
    logic                   valid3;
    logic                   valid4;
    logic                   ready1;
    logic                   ready2;
    logic                   ready3;
    logic                   ready4;
    logic [number_bits-1:0] out;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             out_lane;
    logic                   out_last;
    logic [7:0]             group_cnt;

    modport master (
        output in1, in2, in3, in4,
        output valid1, valid2, valid3, valid4,
        output out_ready,
        input  ready1, ready2, ready3, ready4,
        input  out, out_valid, out_lane, out_last, group_cnt
    );

    modport slave (
        input  in1, in2, in3, in4,
        input  valid1, valid2, valid3, valid4,
        input  out_ready,
        output ready1, ready2, ready3, ready4,
        output out, out_valid, out_lane, out_last, group_cnt
    );
endinterface

// File: rtl/merge4_1.sv
// Four-lane strict round-robin merger: lanes are served 0,1,2,3 in order without skipping,
// into a single registered output stage that sustains one word per cycle.
module merge4_1 #(
    parameter int number_bits = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    merge4_1_if.slave bus
);

    logic [1:0]             ptr_q,       ptr_d;
    logic [number_bits-1:0] out_q,       out_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             out_lane_q,  out_lane_d;
    logic                   out_last_q,  out_last_d;
    logic [7:0]             group_cnt_q, group_cnt_d;

    logic                   sel_valid;
    logic [number_bits-1:0] sel_data;
    logic                   can_load;
    logic                   lane_open;
    logic                   in_xfer;
    logic                   out_xfer;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        unique case (ptr_q)
            2'd0: begin sel_valid = bus.valid1; sel_data = bus.in1; end
            2'd1: begin sel_valid = bus.valid2; sel_data = bus.in2; end
            2'd2: begin sel_valid = bus.valid3; sel_data = bus.in3; end
            2'd3: begin sel_valid = bus.valid4; sel_data = bus.in4; end
            default: begin sel_valid = 1'b0; sel_data = '0; end
        endcase
    end

    // Ready depends only on state, out_ready, sync and reset, never on any valid.
    assign can_load  = !out_valid_q || bus.out_ready;
    assign lane_open = rst_n && can_load && !sync;

    assign bus.ready1 = lane_open && (ptr_q == 2'd0);
    assign bus.ready2 = lane_open && (ptr_q == 2'd1);
    assign bus.ready3 = lane_open && (ptr_q == 2'd2);
    assign bus.ready4 = lane_open && (ptr_q == 2'd3);

    assign in_xfer  = lane_open && sel_valid;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        ptr_d       = ptr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;
        group_cnt_d = group_cnt_q;
        if (sync) begin
            // Restart discards the pending word without counting it as delivered.
            ptr_d       = 2'd0;
            out_valid_d = 1'b0;
        end else begin
            if (out_xfer && out_last_q) begin
                group_cnt_d = group_cnt_q + 8'd1;
            end
            if (in_xfer) begin
                out_d       = sel_data;
                out_lane_d  = ptr_q;
                out_last_d  = (ptr_q == 2'd3);
                out_valid_d = 1'b1;
                ptr_d       = ptr_q + 2'd1;
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= 2'd0;
            out_last_q  <= 1'b0;
            group_cnt_q <= 8'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
            group_cnt_q <= group_cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.out_last  = out_last_q;
    assign bus.group_cnt = group_cnt_q;

endmodule

// File: doc/merge4_1.md
MERGE4_1 -- requirements
Module: merge4_1

Interface
REQ-001 Parameter number_bits, default 16, width of each data lane and of the output word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sync  input  1  synchronous restart of the lane sequence, active-high.
REQ-005 in1, in2, in3, in4  input  number_bits each  lane data words (lane 0..3).
REQ-006 valid1, valid2, valid3, valid4  input  1 each  lane word present.
REQ-007 ready1, ready2, ready3, ready4  output  1 each  block accepts the lane word this cycle.
REQ-008 out  output  number_bits  registered merged data word.
REQ-009 out_valid  output  1  out holds an undelivered word.
REQ-010 out_ready  input  1  downstream accepts out this cycle.
REQ-011 out_lane  output  2  lane index (0..3) that out came from.
REQ-012 out_last  output  1  high when out came from lane 3, marking the end of a group.
REQ-013 group_cnt  output  8  count of groups completed on the output side.

Function
REQ-014 The block SHALL hold a 2-bit lane pointer ptr, which selects the only lane allowed to transfer.
REQ-015 Lanes SHALL be served in strict order 0,1,2,3,0,...; an empty lane SHALL NOT be skipped.
REQ-016 can_load = !out_valid || out_ready.
REQ-017 ready(k) SHALL be high exactly when ptr==k, can_load==1 and sync==0; all other ready lines SHALL be low.
REQ-018 Input transfer: ready(ptr) && valid(ptr) at an edge.
REQ-019 On an input transfer, out<=in(ptr), out_lane<=ptr, out_last<=(ptr==3), out_valid<=1 and ptr<=ptr+1 (3 wraps to 0).
REQ-020 Output transfer: out_valid && out_ready at an edge.
REQ-021 Output transfer without an input transfer: out_valid<=0, while out, out_lane and out_last hold their values.
REQ-022 Output and input transfer on the same edge: the new word SHALL be loaded, out_valid SHALL stay 1, and throughput SHALL be 1 word/cycle.
REQ-023 out_valid high and out_ready low (stall): out, out_lane and out_last SHALL hold, all ready lines low, ptr holds.
REQ-024 Latency: a word accepted at edge N SHALL appear on out with out_valid=1 right after edge N.
REQ-025 group_cnt SHALL increment by 1 on each output transfer where out_last==1, wrapping 255 to 0.
REQ-026 Input values on non-selected lanes SHALL be ignored, whatever their valid state.
REQ-027 When sync==1 at an edge: ptr<=0, out_valid<=0 (the pending word is discarded), group_cnt holds, and no input transfer occurs.
REQ-028 If sync and an output transfer coincide, sync wins and group_cnt SHALL NOT increment.
REQ-029 The block SHALL contain no combinational path from any valid input to any ready output.
REQ-030 The block SHALL contain no combinational path from data inputs to out.

Reset
REQ-031 While rst_n==0, the block SHALL asynchronously force ptr=0, out=0, out_valid=0, out_lane=0, out_last=0 and group_cnt=0.
REQ-032 While rst_n==0, ready1..4 SHALL be low, because ready is gated internally by reset.
REQ-033 Reset mid-group SHALL discard the partial group and the pending word; after release, service SHALL restart at lane 0.
REQ-034 On the first edge after rst_n rises, the block SHALL be able to accept lane 0.

Verification
REQ-035 Streaming:
- Stimulus: after reset, all lanes valid with in1..4 = 0x0011, 0x0022, 0x0033, 0x0044, and out_ready=1.
- Response: out = 0x0011, 0x0022, 0x0033, 0x0044, 0x0011, ... on consecutive cycles, out_last high on every 0x0044, group_cnt = 1 after the first 0x0044 is delivered.
REQ-036 Strict order:
- Stimulus: only valid2 and valid4 high.
- Response: no transfer, ready1 stays high, out_valid stays 0.
- Then raise valid1.
- Response: lanes 0 and 1 transfer, and the block stalls at lane 2 with ready3=1.
REQ-037 Backpressure:
- Stimulus: out_ready=0 after the first word 0x0011.
- Response: out holds 0x0011, out_valid=1, all ready lines low, ptr=1.
- Then out_ready=1.
- Response: 0x0022 follows with no loss or duplication.
REQ-038 Sync:
- Stimulus: sync pulse with ptr=2 and out_valid=1.
- Response: next cycle out_valid=0, ready1=1, group_cnt unchanged.
REQ-039 Async reset:
- Stimulus: rst_n low mid-cycle during streaming.
- Response: outputs 0 immediately, before the next edge; after release, the first word out is from lane 0.
REQ-040 Wrap:
- Stimulus: 256 complete groups.
- Response: group_cnt returns to 0.
